// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generation stage for the RV32I core. Issues
//               one fetch request at a time to inst_fetch, registers the
//               returned instruction with its PC for decode, and handles
//               decode stall and execute redirects (with in-flight discard).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CCLK,
    input  logic        CRST,
    output logic        PC_VALID,
    output logic [31:0] PC,
    input  logic        INST_VALID,
    input  logic [31:0] INST,
    input  logic        MEM_WAIT,
    input  logic        STALL,
    input  logic        JMP_DO,
    input  logic [31:0] JMP_PC,
    output logic        FETCH_VALID,
    output logic [31:0] FETCH_PC,
    output logic [31:0] FETCH_INST
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Word alignment is enforced on the reset PC as well as on redirects.
    localparam logic [31:0] c_reset_pc = {RESET_VECTOR[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_discard;
    logic        w_discard_nxt;
    logic        r_fetch_valid;
    logic        w_fetch_valid_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_fetch_inst;
    logic [31:0] w_fetch_inst_nxt;

    logic [31:0] w_jmp_tgt;
    logic        w_issue;
    logic        w_unused_jmp_lsb;

    assign w_jmp_tgt        = {JMP_PC[31:2], 2'b00};
    assign w_unused_jmp_lsb = ^JMP_PC[1:0];

    // A request goes out only from S_ISSUE when the fetch unit is free.
    assign w_issue = (r_state == S_ISSUE) && !MEM_WAIT && !CRST;

    assign PC_VALID    = w_issue;
    assign PC          = r_pc;
    assign FETCH_VALID = r_fetch_valid;
    assign FETCH_PC    = r_fetch_pc;
    assign FETCH_INST  = r_fetch_inst;

    // State and datapath registers.
    always_ff @(posedge CCLK) begin
        if (CRST) begin
            r_state       <= S_IDLE;
            r_pc          <= c_reset_pc;
            r_discard     <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= 32'd0;
            r_fetch_inst  <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_discard     <= w_discard_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_fetch_inst  <= w_fetch_inst_nxt;
        end
    end

    // Next-state logic; a redirect takes priority over the normal flow.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_discard_nxt     = r_discard;
        w_fetch_valid_nxt = r_fetch_valid;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_fetch_inst_nxt  = r_fetch_inst;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_ISSUE;
                if (JMP_DO) begin
                    w_pc_nxt = w_jmp_tgt;
                end
            end
            S_ISSUE: begin
                if (JMP_DO) begin
                    w_pc_nxt = w_jmp_tgt;
                end
                if (w_issue) begin
                    w_state_nxt = S_WAIT;
                    // The request already left with the old PC; drop its reply.
                    if (JMP_DO) begin
                        w_discard_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (JMP_DO) begin
                    w_pc_nxt = w_jmp_tgt;
                    if (INST_VALID) begin
                        // Reply arrives with the redirect: drop it right here.
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_ISSUE;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (INST_VALID) begin
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_ISSUE;
                    end else begin
                        w_fetch_valid_nxt = 1'b1;
                        w_fetch_pc_nxt    = r_pc;
                        w_fetch_inst_nxt  = INST;
                        w_pc_nxt          = r_pc + 32'd4;
                        w_state_nxt       = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (JMP_DO) begin
                    w_fetch_valid_nxt = 1'b0;
                    w_pc_nxt          = w_jmp_tgt;
                    w_state_nxt       = S_ISSUE;
                end else if (!STALL) begin
                    w_fetch_valid_nxt = 1'b0;
                    w_state_nxt       = S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen. A fetch responder answers
//               each request; a monitor keeps a transaction-level model of
//               the fetch protocol and a scoreboard of expected decode
//               outputs and request addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] C_RV = 32'h0000_0000;

    logic        CCLK = 1'b0;
    logic        CRST;
    logic        PC_VALID;
    logic [31:0] PC;
    logic        INST_VALID;
    logic [31:0] INST;
    logic        MEM_WAIT;
    logic        STALL;
    logic        JMP_DO;
    logic [31:0] JMP_PC;
    logic        FETCH_VALID;
    logic [31:0] FETCH_PC;
    logic [31:0] FETCH_INST;

    pc_gen #(.RESET_VECTOR(C_RV)) dut (
        .CCLK        (CCLK),
        .CRST        (CRST),
        .PC_VALID    (PC_VALID),
        .PC          (PC),
        .INST_VALID  (INST_VALID),
        .INST        (INST),
        .MEM_WAIT    (MEM_WAIT),
        .STALL       (STALL),
        .JMP_DO      (JMP_DO),
        .JMP_PC      (JMP_PC),
        .FETCH_VALID (FETCH_VALID),
        .FETCH_PC    (FETCH_PC),
        .FETCH_INST  (FETCH_INST)
    );

    always #5 CCLK = ~CCLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    // Written only by the monitor.
    int          checks = 0;
    int          errors = 0;
    int          req_count = 0;
    int          consumed = 0;
    int          dir_rd = 0;
    fetch_t      exp_q[$];

    // Written only by the driver.
    int          timeouts = 0;
    int          dir_wr = 0;
    logic [31:0] dir_exp [0:31];
    bit          done = 1'b0;
    bit          rnd_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / reference model / scoreboard ----------------
    initial begin : p_mon
        bit          m_valid;
        bit          m_idle;
        bit          m_out;
        bit          m_fv;
        bit          m_killed;
        bit          was_out;
        bit          exp_pcv;
        int          rst_cnt;
        logic [31:0] m_next_pc;
        logic [31:0] m_req_pc;
        logic [31:0] tgt;
        fetch_t      f;
        m_valid = 0; m_idle = 0; m_out = 0; m_fv = 0; m_killed = 0;
        rst_cnt = 0; m_next_pc = C_RV; m_req_pc = C_RV;
        forever begin
            @(negedge CCLK);
            if (done) begin
                chk("timeouts", 32'(timeouts), 32'd0);
                chk("directed_requests_pending", 32'(dir_wr - dir_rd), 32'd0);
                chk("enough_consumed", 32'(consumed >= 50), 32'd1);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (CRST) begin
                chk("pc_valid_in_reset", {31'd0, PC_VALID}, 32'd0);
                rst_cnt++;
                if (rst_cnt >= 2) begin
                    chk("reset_fetch_valid", {31'd0, FETCH_VALID}, 32'd0);
                    chk("reset_fetch_pc", FETCH_PC, 32'd0);
                    chk("reset_fetch_inst", FETCH_INST, 32'd0);
                    chk("reset_pc", PC, C_RV);
                end
                m_valid = 1; m_idle = 1; m_out = 0; m_fv = 0; m_killed = 0;
                m_next_pc = C_RV;
                exp_q.delete();
            end else if (m_valid) begin
                rst_cnt = 0;
                // A new request is allowed only when nothing is in flight or held.
                exp_pcv = !m_idle && !m_out && !m_fv && !MEM_WAIT;
                chk("pc_valid", {31'd0, PC_VALID}, {31'd0, exp_pcv});
                chk("fetch_valid", {31'd0, FETCH_VALID}, {31'd0, m_fv});
                if (m_fv) begin
                    if (exp_q.size() == 0) begin
                        chk("fetch_queue_empty", 32'd0, 32'd1);
                    end else begin
                        chk("fetch_pc", FETCH_PC, exp_q[0].pc);
                        chk("fetch_inst", FETCH_INST, exp_q[0].inst);
                    end
                end
                if (PC_VALID) begin
                    chk("request_pc", PC, m_next_pc);
                    if (dir_rd < dir_wr) begin
                        chk("directed_request_pc", PC, dir_exp[dir_rd]);
                        dir_rd++;
                    end
                    req_count++;
                end
                // Advance the model by one cycle.
                was_out = m_out;
                tgt = {JMP_PC[31:2], 2'b00};
                m_idle = 0;
                if (m_fv && (JMP_DO || !STALL)) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (!JMP_DO) consumed++;
                    m_fv = 0;
                end
                if (INST_VALID && was_out) begin
                    if (!m_killed && !JMP_DO) begin
                        f.pc = m_req_pc;
                        f.inst = INST;
                        exp_q.push_back(f);
                        m_fv = 1;
                        m_next_pc = m_req_pc + 32'd4;
                    end
                    m_out = 0;
                    m_killed = 0;
                end
                if (PC_VALID) begin
                    m_out = 1;
                    m_killed = 0;
                    m_req_pc = m_next_pc;
                end
                if (JMP_DO) begin
                    m_next_pc = tgt;
                    if (m_out) m_killed = 1;
                end
            end
        end
    end

    // ---------------- driver and fetch responder ----------------
    int rsp_cnt = 0;
    int last_req = 0;

    task automatic tick();
        @(posedge CCLK);
        #1;
        INST_VALID = 1'b0;
        JMP_DO = 1'b0;
        INST = $urandom;
        if (CRST) begin
            rsp_cnt = 0;
            last_req = req_count;
        end else begin
            if (req_count != last_req) begin
                last_req = req_count;
                rsp_cnt = rnd_mode ? int'($urandom_range(1, 4)) : 2;
            end
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    INST_VALID = 1'b1;
                    INST = rnd_mode ? $urandom : 32'h0000_0013;
                end
            end
        end
    endtask

    task automatic push_dir(input logic [31:0] a);
        dir_exp[dir_wr] = a;
        dir_wr++;
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (PC_VALID !== 1'b1 && n < 100);
        if (PC_VALID !== 1'b1) begin
            timeouts++;
            $display("FAIL wait_request: no PC_VALID within %0d cycles", n);
        end
    endtask

    task automatic wait_fv(input logic [31:0] a);
        int n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (!(FETCH_VALID === 1'b1 && FETCH_PC === a) && n < 100);
        if (!(FETCH_VALID === 1'b1 && FETCH_PC === a)) begin
            timeouts++;
            $display("FAIL wait_fetch: no FETCH_VALID for pc %h within %0d cycles", a, n);
        end
    endtask

    task automatic wait_instv();
        int n = 0;
        do begin
            tick();
            n++;
        end while (INST_VALID !== 1'b1 && n < 100);
        if (INST_VALID !== 1'b1) begin
            timeouts++;
            $display("FAIL wait_inst_valid: no response within %0d cycles", n);
        end
    endtask

    initial begin : p_drv
        CRST = 1'b1; MEM_WAIT = 1'b0; STALL = 1'b0; JMP_DO = 1'b0;
        JMP_PC = 32'd0; INST_VALID = 1'b0; INST = 32'd0;

        // Reset, then three sequential fetches.
        tick(); tick();
        push_dir(32'h0); push_dir(32'h4); push_dir(32'h8);
        CRST = 1'b0;
        repeat (3) wait_req();
        repeat (6) tick();

        // MEM_WAIT held for five cycles in the issue state.
        CRST = 1'b1;
        tick(); tick();
        CRST = 1'b0; MEM_WAIT = 1'b1;
        push_dir(32'h0);
        repeat (6) tick();
        MEM_WAIT = 1'b0;

        // Stall for four cycles while PC 4 is held.
        wait_fv(32'h4);
        push_dir(32'h8);
        STALL = 1'b1;
        repeat (4) tick();
        STALL = 1'b0;

        // Redirect while the fetch of PC 8 is in flight.
        wait_req();
        tick();
        JMP_DO = 1'b1; JMP_PC = 32'h0000_0102;
        push_dir(32'h100);
        wait_fv(32'h100);

        // Redirect while holding under stall.
        STALL = 1'b1;
        tick();
        JMP_DO = 1'b1; JMP_PC = 32'h0000_0200;
        push_dir(32'h200);
        tick();
        STALL = 1'b0;
        wait_req();

        // Redirect coincident with the returning instruction.
        wait_instv();
        JMP_DO = 1'b1; JMP_PC = 32'h0000_0300;
        push_dir(32'h300);
        wait_req();

        // Redirect to the top word, then wrap to zero.
        tick();
        JMP_DO = 1'b1; JMP_PC = 32'hFFFF_FFFF;
        push_dir(32'hFFFF_FFFC); push_dir(32'h0);
        wait_req();
        wait_req();
        repeat (6) tick();

        // Randomized traffic.
        rnd_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            CRST = ($urandom_range(0, 199) == 0);
            MEM_WAIT = ($urandom_range(0, 9) < 3);
            STALL = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                JMP_DO = 1'b1;
                JMP_PC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            end
        end
        CRST = 1'b0; MEM_WAIT = 1'b0; STALL = 1'b0;
        repeat (20) tick();
        done = 1'b1;
    end

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
